snake_axi_full_responder: RTL
=============================

// Module: snake_axi_full_responder
// PURPOSE
//  AXI4-full slave (responder) with a 32-bit on-chip word memory, backing board/tile state for the uB Snake design.
//  Serves INCR/FIXED bursts of 1..256 beats on independent read and write channels.
//  Sits behind the MicroBlaze/VIP master in the block design.
// PARAMETERS
//  C_S_AXI_ID_WIDTH    1   AXI ID width; BID/RID echo the accepted AWID/ARID
//  C_S_AXI_ADDR_WIDTH  12  byte address width; memory = 2**(ADDR_W-2) words
//  C_S_AXI_DATA_WIDTH  32  fixed at 32; elaboration $error for any other value
// PORTS
//  S_AXI_ACLK                     in   1       single clock
//  S_AXI_ARESET                   in   1       asynchronous, active-high reset
//  S_AXI_AWID / S_AXI_ARID        in   ID_W    request ID
//  S_AXI_AWADDR / S_AXI_ARADDR    in   ADDR_W  burst start byte address
//  S_AXI_AWLEN / S_AXI_ARLEN      in   8       beats-1
//  S_AXI_AWSIZE / S_AXI_ARSIZE    in   3       only 3'b010 is legal
//  S_AXI_AWBURST / S_AXI_ARBURST  in   2       00 FIXED, 01 INCR, 10 WRAP
//  S_AXI_AWVALID / S_AXI_ARVALID  in   1       request valid
//  S_AXI_AWREADY / S_AXI_ARREADY  out  1       request accept
//  S_AXI_WDATA    in   32  write beat data
//  S_AXI_WSTRB    in   4   per-byte write enable
//  S_AXI_WLAST    in   1   last write beat
//  S_AXI_WVALID   in   1   write beat valid
//  S_AXI_WREADY   out  1   write beat accept
//  S_AXI_BID      out  ID_W  write response ID
//  S_AXI_BRESP    out  2     00 OKAY / 10 SLVERR
//  S_AXI_BVALID   out  1     write response valid
//  S_AXI_BREADY   in   1     write response accept
//  S_AXI_RID      out  ID_W  read ID
//  S_AXI_RDATA    out  32    read beat data
//  S_AXI_RRESP    out  2     read response
//  S_AXI_RLAST    out  1     last read beat
//  S_AXI_RVALID   out  1     read beat valid
//  S_AXI_RREADY   in   1     read beat accept
//  LOCK/CACHE/PROT/QOS/REGION/USER are not ports; tied off in the block design.
// BEHAVIOUR
//  Reset: all READY/VALID outputs 0; B*/R* ID, RESP and DATA 0; RLAST 0; both FSMs idle; memory contents undefined.
//  Write FSM: W_IDLE(AWREADY=1) -AW hs-> W_DATA(WREADY=1) -beat cnt==AWLEN hs-> W_RESP(BVALID=1) -BREADY-> W_IDLE.
//   - Each W handshake writes the strobed bytes at the current address.
//   - BVALID rises the cycle after the final W handshake.
//   - Only one write outstanding; AWREADY=0 outside W_IDLE.
//  Read FSM: R_IDLE(ARREADY=1) -AR hs-> R_DATA -final beat RVALID&RREADY-> R_IDLE.
//   - First RVALID the cycle after the AR handshake.
//   - Next beat loads in the same cycle as the handshake, so back-to-back beats are possible.
//   - RDATA/RLAST/RRESP are held stable while RVALID=1 and RREADY=0.
//  Read and write channels run independently and may be active in the same cycle.
//   - Same-word collision: a read beat loaded in the same cycle as a write sees the OLD data.
//  Address: word index = addr[ADDR_W-1:2]; addr[1:0] is ignored.
//   - INCR: index+1 per beat, wraps modulo memory size.
//   - FIXED: index is constant for the whole burst.
//  Errors (RESP=SLVERR; the burst still completes with its full beat count):
//   - SIZE != 3'b010, or burst type 11: writes are suppressed; reads return 0.
//   - WLAST mismatch (asserted early, or missing on beat AWLEN): data is still written, BRESP=SLVERR.
//     The burst ends on beat count, not on WLAST.
//  Reset mid-burst: both FSMs return to idle immediately. Partial writes remain in memory.
// CONFIGURATION
//  SNAKE_AXI_WRAP_EN defined: WRAP bursts are supported.
//   - Legal LEN is 1/3/7/15; the address wraps on a (LEN+1)*4-byte aligned boundary.
//   - Any other LEN with WRAP gives SLVERR.
//  SNAKE_AXI_WRAP_EN undefined: every WRAP burst gives SLVERR; writes are suppressed; reads return 0.
// STRUCTURE
//  snake_axi_pkg holds:
//   - burst_t and resp_t enums, plus OKAY/SLVERR constants;
//   - the wr_state_t and rd_state_t FSM enums;
//   - SIZE_WORD = 3'b010.
//  Sub-module snake_axi_burst_addr: combinational next-word-index calculator (burst, len, index) -> next index.
//   - Instantiated once for the write channel and once for the read channel.
// TESTING
//  1. Write INCR, addr 0, LEN 7, data 1..8, STRB F -> BRESP OKAY, BID echoed; INCR read back -> RDATA 1..8, RLAST on beat 8 only.
//  2. Read with RREADY toggled 1,0,1,0 -> no beat dropped or duplicated; RDATA stable while stalled.
//  3. FIXED write of 3 beats to 0x10 (AA, BB, CC), then single read -> 0xCC.
//  4. Write STRB 4'b0011 of 0xDEADBEEF over 0 -> read back 0x0000BEEF; AWSIZE=1 write -> SLVERR, memory unchanged.
//  5. INCR write starting at the last word, LEN 1 -> second beat lands at word 0.
//     WRAP LEN 3 at 0x08 -> order 08, 0C, 00, 04 with the macro; SLVERR without it.
//  6. Concurrent 16-beat write and 16-beat read to disjoint regions -> both complete at full rate.
//     ARESET pulse mid-burst -> all VALIDs 0, FSMs idle, next burst correct.

Source files
------------

// File: rtl/snake_axi_pkg.sv
// Shared types and constants for the Snake AXI4-full responder.
// Build option: define SNAKE_AXI_WRAP_EN to accept WRAP bursts of 2/4/8/16 beats.
package snake_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    localparam resp_t OKAY   = RESP_OKAY;
    localparam resp_t SLVERR = RESP_SLVERR;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE,
        R_DATA
    } rd_state_t;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    // A request is served normally only for 32-bit beats and a supported burst type.
    function automatic logic burst_legal(input logic [2:0] size, input burst_t burst,
                                         input logic [7:0] len);
        logic ok;
        case (burst)
            BURST_FIXED, BURST_INCR: ok = 1'b1;
`ifdef SNAKE_AXI_WRAP_EN
            BURST_WRAP: ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
`endif
            default: ok = 1'b0;
        endcase
`ifndef SNAKE_AXI_WRAP_EN
        begin
            logic unused_len;
            unused_len = ^len;
        end
`endif
        return ok && (size == SIZE_WORD);
    endfunction

endpackage

// File: rtl/snake_axi_burst_addr.sv
// Next word index for one beat of an AXI burst.
// Build option: SNAKE_AXI_WRAP_EN enables the wrapping address sequence.
module snake_axi_burst_addr
    import snake_axi_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic [1:0]       burst_i,
    input  logic [7:0]       len_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [IDX_W-1:0] next_idx_o
);

    logic [IDX_W-1:0] incr_idx;

    // Natural overflow gives the modulo-memory-size wrap for INCR.
    assign incr_idx = idx_i + 1'b1;

`ifdef SNAKE_AXI_WRAP_EN
    // Legal wrap lengths are 2**n-1 beats, so len doubles as the in-window mask.
    logic [IDX_W-1:0] wrap_mask;
    logic             unused_len_hi;
    assign wrap_mask     = IDX_W'(len_i[3:0]);
    assign unused_len_hi = ^len_i[7:4];
`else
    logic unused_len;
    assign unused_len = ^len_i;
`endif

    // Select the step rule for the burst type; error bursts simply hold the index.
    always_comb begin : next_idx_sel
        next_idx_o = idx_i;
        case (burst_t'(burst_i))
            BURST_INCR: next_idx_o = incr_idx;
`ifdef SNAKE_AXI_WRAP_EN
            BURST_WRAP: next_idx_o = (idx_i & ~wrap_mask) | (incr_idx & wrap_mask);
`endif
            default:    next_idx_o = idx_i;
        endcase
    end

endmodule

// File: rtl/snake_axi_full_responder.sv
// AXI4-full responder backed by a 32-bit word memory (board/tile state for uB Snake).
// Independent read and write FSMs; one burst outstanding per channel.
// Build option: SNAKE_AXI_WRAP_EN (WRAP burst support, handled in the package and address unit).
module snake_axi_full_responder
    import snake_axi_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [7:0]                    S_AXI_AWLEN,
    input  logic [2:0]                    S_AXI_AWSIZE,
    input  logic [1:0]                    S_AXI_AWBURST,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WLAST,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_BID,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic [2:0]                    S_AXI_ARSIZE,
    input  logic [1:0]                    S_AXI_ARBURST,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY
);

    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** IDX_W;

    if (C_S_AXI_DATA_WIDTH != 32) begin : g_width_check
        $error("snake_axi_full_responder: C_S_AXI_DATA_WIDTH must be 32");
    end

    logic [31:0] mem [DEPTH];
    logic [31:0] mem_rdata_q;

    // Write channel state
    wr_state_t                 wr_state_q;
    logic                      awready_q, wready_q, bvalid_q;
    logic [C_S_AXI_ID_WIDTH-1:0] bid_q;
    logic [1:0]                bresp_q;
    logic [IDX_W-1:0]          wr_idx_q, wr_idx_d;
    logic [7:0]                wr_len_q, wr_cnt_q;
    logic [1:0]                wr_burst_q;
    logic                      wr_err_q, wr_last_err_q;

    // Read channel state
    rd_state_t                 rd_state_q;
    logic                      arready_q, rvalid_q, rlast_q;
    logic [C_S_AXI_ID_WIDTH-1:0] rid_q;
    logic [1:0]                rresp_q;
    logic [IDX_W-1:0]          rd_idx_q, rd_idx_d, rd_next_idx;
    logic [7:0]                rd_len_q, rd_cnt_q;
    logic [1:0]                rd_burst_q;
    logic                      rd_err_q;

    logic aw_hs, w_hs, w_final, w_last_bad, ar_hs, r_hs, rd_load, mem_we;
    logic [3:0] byte_we;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs      = awready_q & S_AXI_AWVALID;
    assign w_hs       = wready_q & S_AXI_WVALID;
    assign w_final    = w_hs && (wr_cnt_q == wr_len_q);
    assign w_last_bad = S_AXI_WLAST != (wr_cnt_q == wr_len_q);
    assign ar_hs      = arready_q & S_AXI_ARVALID;
    assign r_hs       = rvalid_q & S_AXI_RREADY;
    assign rd_load    = ar_hs | (r_hs & ~rlast_q);
    assign mem_we     = w_hs & ~wr_err_q;

    // The first read beat comes straight from the request address, later ones from the stepper.
    assign rd_idx_d = (rd_state_q == R_IDLE) ? S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2] : rd_next_idx;

    snake_axi_burst_addr #(.IDX_W(IDX_W)) u_wr_addr (
        .burst_i    (wr_burst_q),
        .len_i      (wr_len_q),
        .idx_i      (wr_idx_q),
        .next_idx_o (wr_idx_d)
    );

    snake_axi_burst_addr #(.IDX_W(IDX_W)) u_rd_addr (
        .burst_i    (rd_burst_q),
        .len_i      (rd_len_q),
        .idx_i      (rd_idx_q),
        .next_idx_o (rd_next_idx)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_we
        assign byte_we[gi] = mem_we & S_AXI_WSTRB[gi];
    end

    // Memory port: byte-strobed write, registered read (a same-cycle read sees the old word).
    always_ff @(posedge S_AXI_ACLK) begin : mem_port
        for (int b = 0; b < 4; b++) begin
            if (byte_we[b]) begin
                mem[wr_idx_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
        if (rd_load) begin
            mem_rdata_q <= mem[rd_idx_d];
        end
    end

    // Write FSM: accept address, count beats, then hold the response until taken.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin : wr_fsm
        if (S_AXI_ARESET) begin
            wr_state_q    <= W_IDLE;
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            bvalid_q      <= 1'b0;
            bid_q         <= '0;
            bresp_q       <= '0;
            wr_idx_q      <= '0;
            wr_len_q      <= '0;
            wr_cnt_q      <= '0;
            wr_burst_q    <= '0;
            wr_err_q      <= 1'b0;
            wr_last_err_q <= 1'b0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (aw_hs) begin
                        awready_q     <= 1'b0;
                        wready_q      <= 1'b1;
                        bid_q         <= S_AXI_AWID;
                        wr_idx_q      <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                        wr_len_q      <= S_AXI_AWLEN;
                        wr_cnt_q      <= '0;
                        wr_burst_q    <= S_AXI_AWBURST;
                        wr_err_q      <= !burst_legal(S_AXI_AWSIZE, burst_t'(S_AXI_AWBURST), S_AXI_AWLEN);
                        wr_last_err_q <= 1'b0;
                        wr_state_q    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        wr_idx_q <= wr_idx_d;
                        if (w_last_bad) begin
                            wr_last_err_q <= 1'b1;
                        end
                        if (w_final) begin
                            wready_q   <= 1'b0;
                            bvalid_q   <= 1'b1;
                            bresp_q    <= (wr_err_q || wr_last_err_q || w_last_bad) ? SLVERR : OKAY;
                            wr_state_q <= W_RESP;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // Read FSM: present one beat at a time, loading the next beat on each handshake.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin : rd_fsm
        if (S_AXI_ARESET) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rid_q      <= '0;
            rresp_q    <= '0;
            rd_idx_q   <= '0;
            rd_len_q   <= '0;
            rd_cnt_q   <= '0;
            rd_burst_q <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rlast_q    <= (S_AXI_ARLEN == 8'd0);
                        rid_q      <= S_AXI_ARID;
                        rd_idx_q   <= rd_idx_d;
                        rd_len_q   <= S_AXI_ARLEN;
                        rd_cnt_q   <= '0;
                        rd_burst_q <= S_AXI_ARBURST;
                        rd_err_q   <= !burst_legal(S_AXI_ARSIZE, burst_t'(S_AXI_ARBURST), S_AXI_ARLEN);
                        rresp_q    <= burst_legal(S_AXI_ARSIZE, burst_t'(S_AXI_ARBURST), S_AXI_ARLEN)
                                      ? OKAY : SLVERR;
                        rd_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (rlast_q) begin
                            rvalid_q   <= 1'b0;
                            rlast_q    <= 1'b0;
                            arready_q  <= 1'b1;
                            rd_state_q <= R_IDLE;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + 8'd1;
                            rlast_q  <= ((rd_cnt_q + 8'd1) == rd_len_q);
                            rd_idx_q <= rd_idx_d;
                        end
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BID     = bid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RID     = rid_q;
    // Error bursts and idle cycles show zero data; the memory register itself is not reset.
    assign S_AXI_RDATA   = (rvalid_q && !rd_err_q) ? mem_rdata_q : 32'h0;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RVALID  = rvalid_q;

endmodule
